// File: rtl/axi_lite_sram.sv
// AXI-lite slave SRAM: word-addressed array behind independent read and
// write channel FSMs, each with a fixed response latency, byte-strobed
// writes and SLVERR for addresses outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid is held by its source until that edge, and every
// ready here comes straight from a register, never from the opposite valid.
module axi_lite_sram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    RD_LATENCY = 2,
    parameter int                    WR_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [1:0]            rd_state_o,
    output logic [1:0]            wr_state_o
);
    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [7:0] RD_LOAD = 8'(RD_LATENCY - 1);
    localparam logic [7:0] WR_LOAD = 8'(WR_LATENCY - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Address decode: offset from BASE_ADDR wraps, so anything below the base
    // lands far out of range. DEPTH is a power of two, so in-range simply
    // means all offset bits above the word index are zero.
    logic [ADDR_WIDTH-1:0] w_ar_off, w_aw_off;
    logic [IDX_W-1:0]      w_ar_idx, w_aw_idx;
    logic                  w_ar_inr, w_aw_inr;
    logic                  w_unused_addr;
    assign w_ar_off      = araddr_i - BASE_ADDR;
    assign w_aw_off      = awaddr_i - BASE_ADDR;
    assign w_ar_idx      = w_ar_off[IDX_W+1:2];
    assign w_aw_idx      = w_aw_off[IDX_W+1:2];
    assign w_ar_inr      = (w_ar_off[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign w_aw_inr      = (w_aw_off[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign w_unused_addr = ^{w_ar_off[1:0], w_aw_off[1:0]};

    // ---------------- read channel ----------------
    rd_state_t        r_rd_state, w_rd_next;
    logic             r_arready, r_rvalid, r_rd_inr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [IDX_W-1:0] r_rd_idx;
    logic [7:0]       r_rd_cnt;
    logic             w_ar_hs, w_rd_fire;

    assign w_ar_hs   = arvalid_i && r_arready;
    assign w_rd_fire = (r_rd_state == R_WAIT) && (r_rd_cnt == 8'd0);

    // Read FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_rd_state <= R_IDLE;
        else        r_rd_state <= w_rd_next;
    end

    // Read next-state: accept AR, count down the latency, hold the response.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs)   w_rd_next = R_WAIT;
            R_WAIT:  if (w_rd_fire) w_rd_next = R_RESP;
            R_RESP:  if (rready_i)  w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Read datapath: arready follows the next state so it rises one cycle
    // after reset or after the R handshake; rdata is captured once and held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rd_idx  <= '0;
            r_rd_inr  <= 1'b0;
            r_rd_cnt  <= 8'd0;
        end else begin
            r_arready <= (w_rd_next == R_IDLE);
            if (w_ar_hs) begin
                r_rd_idx <= w_ar_idx;
                r_rd_inr <= w_ar_inr;
                r_rd_cnt <= RD_LOAD;
            end else if ((r_rd_state == R_WAIT) && (r_rd_cnt != 8'd0)) begin
                r_rd_cnt <= r_rd_cnt - 8'd1;
            end
            if (w_rd_fire) begin
                // Same-edge write commit is not yet visible: old data wins.
                r_rdata  <= r_rd_inr ? r_mem[r_rd_idx] : '0;
                r_rvalid <= 1'b1;
            end else if (r_rvalid && rready_i) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_t        r_wr_state, w_wr_next;
    logic             r_awready, r_wready, r_bvalid, r_aw_held, r_w_held, r_wr_inr;
    logic [1:0]       r_bresp;
    logic [IDX_W-1:0] r_wr_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [7:0]       r_wr_cnt;
    logic             w_aw_hs, w_w_hs, w_wr_start, w_wr_fire;
    logic             w_aw_held_next, w_w_held_next;

    assign w_aw_hs    = awvalid_i && r_awready;
    assign w_w_hs     = wvalid_i && r_wready;
    assign w_wr_start = (r_wr_state == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_fire  = (r_wr_state == W_WAIT) && (r_wr_cnt == 8'd0);

    // Write FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_wr_state <= W_IDLE;
        else        r_wr_state <= w_wr_next;
    end

    // Write next-state and captured-flag bookkeeping for AW/W in any order.
    always_comb begin
        w_wr_next      = r_wr_state;
        w_aw_held_next = r_aw_held;
        w_w_held_next  = r_w_held;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs)    w_aw_held_next = 1'b1;
                if (w_w_hs)     w_w_held_next  = 1'b1;
                if (w_wr_start) w_wr_next      = W_WAIT;
            end
            W_WAIT: if (w_wr_fire) w_wr_next = W_RESP;
            W_RESP: begin
                if (bready_i) begin
                    w_wr_next      = W_IDLE;
                    w_aw_held_next = 1'b0;
                    w_w_held_next  = 1'b0;
                end
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Write datapath: each ready drops after its own capture, response is
    // generated after the latency and held until bready.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_inr  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wr_cnt  <= 8'd0;
        end else begin
            r_aw_held <= w_aw_held_next;
            r_w_held  <= w_w_held_next;
            r_awready <= (w_wr_next == W_IDLE) && !w_aw_held_next;
            r_wready  <= (w_wr_next == W_IDLE) && !w_w_held_next;
            if (w_aw_hs) begin
                r_wr_idx <= w_aw_idx;
                r_wr_inr <= w_aw_inr;
            end
            if (w_w_hs) begin
                r_wdata <= wdata_i;
                r_wstrb <= wstrb_i;
            end
            if (w_wr_start) begin
                r_wr_cnt <= WR_LOAD;
            end else if ((r_wr_state == W_WAIT) && (r_wr_cnt != 8'd0)) begin
                r_wr_cnt <= r_wr_cnt - 8'd1;
            end
            if (w_wr_fire) begin
                r_bresp  <= r_wr_inr ? 2'b00 : 2'b10;
                r_bvalid <= 1'b1;
            end else if (r_bvalid && bready_i) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Storage array: byte-masked commit, never reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_fire && r_wr_inr) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (r_wstrb[b]) r_mem[r_wr_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
        end
    end

    assign arready_o  = r_arready;
    assign rvalid_o   = r_rvalid;
    assign rdata_o    = r_rdata;
    assign awready_o  = r_awready;
    assign wready_o   = r_wready;
    assign bvalid_o   = r_bvalid;
    assign bresp_o    = r_bresp;
    assign rd_state_o = r_rd_state;
    assign wr_state_o = r_wr_state;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench for axi_lite_sram: write/read, strobes, AW/W ordering,
// backpressure, out-of-range decode and reset during a write.
module tb_axi_lite_sram;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;
  localparam int LIMIT  = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic [3:0]  wstrb = '0;
  logic        arready_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  bresp_o, rd_state_o, wr_state_o;

  axi_lite_sram dut (
    .clk_i(clk), .rst_i(rst_n),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready_o),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
    .rd_state_o(rd_state_o), .wr_state_o(wr_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Read: expected data comes from the front of exp_q; hold = cycles of rready=0.
  task automatic axi_read(input logic [31:0] addr, input int hold, input string tag);
    logic [31:0] exp;
    int n;
    int lat;
    exp = exp_q.pop_front();
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready_o && n < LIMIT) begin @(negedge clk); n++; end
    check({tag, "_ar_wait"}, 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid_o && lat < LIMIT) begin @(negedge clk); lat++; end
    check({tag, "_rd_lat"}, 32'(lat), 32'(RD_LAT));
    check({tag, "_rdata"}, rdata_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_rvalid_hold"}, 32'(rvalid_o), 32'd1);
      check({tag, "_rdata_hold"}, rdata_o, exp);
      check({tag, "_arready_hold"}, 32'(arready_o), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check({tag, "_rvalid_clr"}, 32'(rvalid_o), 32'd0);
    check({tag, "_arready_back"}, 32'(arready_o), 32'd1);
  endtask

  // Write: AW/W presented after their own delays; abort pulls reset low
  // once the write is waiting on its latency.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int hold,
                           input logic [1:0] exp_resp, input bit abort, input string tag);
    int c;
    int lat;
    bit aw_done;
    bit w_done;
    c = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && c < LIMIT) begin
      @(negedge clk);
      if (aw_done) check({tag, "_awready_drop"}, 32'(awready_o), 32'd0);
      if (w_done)  check({tag, "_wready_drop"}, 32'(wready_o), 32'd0);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      if (awvalid && awready_o) aw_done = 1;
      if (wvalid && wready_o)   w_done = 1;
      c++;
    end
    check({tag, "_hs_wait"}, 32'(aw_done && w_done), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    if (abort) begin
      rst_n = 1'b0;
      #1;
      check({tag, "_rst_bvalid"}, 32'(bvalid_o), 32'd0);
      check({tag, "_rst_awready"}, 32'(awready_o), 32'd0);
      check({tag, "_rst_wready"}, 32'(wready_o), 32'd0);
      check({tag, "_rst_arready"}, 32'(arready_o), 32'd0);
      return;
    end
    lat = 0;
    while (!bvalid_o && lat < LIMIT) begin @(negedge clk); lat++; end
    check({tag, "_wr_lat"}, 32'(lat), 32'(WR_LAT));
    check({tag, "_bresp"}, 32'(bresp_o), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_bvalid_hold"}, 32'(bvalid_o), 32'd1);
      check({tag, "_bresp_hold"}, 32'(bresp_o), 32'(exp_resp));
      check({tag, "_awready_hold"}, 32'(awready_o), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check({tag, "_bvalid_clr"}, 32'(bvalid_o), 32'd0);
    check({tag, "_awready_back"}, 32'(awready_o), 32'd1);
    check({tag, "_wready_back"}, 32'(wready_o), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check({tag, "_single_b"}, 32'(bvalid_o), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, 32'(arready_o), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid_o), 32'd0);
    check({tag, "_rdata"}, rdata_o, 32'd0);
    check({tag, "_awready"}, 32'(awready_o), 32'd0);
    check({tag, "_wready"}, 32'(wready_o), 32'd0);
    check({tag, "_bvalid"}, 32'(bvalid_o), 32'd0);
    check({tag, "_bresp"}, 32'(bresp_o), 32'd0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    check({tag, "_arready_first"}, 32'(arready_o), 32'd0);
    @(negedge clk);
    check({tag, "_arready_up"}, 32'(arready_o), 32'd1);
    check({tag, "_awready_up"}, 32'(awready_o), 32'd1);
    check({tag, "_wready_up"}, 32'(wready_o), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    release_reset("por");

    // Write then read, AW and W in the same cycle.
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 0, "wr10");
    exp_q.push_back(32'hDEAD_BEEF);
    axi_read(32'h8000_0010, 0, "rd10");

    // Partial strobe over a preloaded word.
    axi_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, 0, 2'b00, 0, "pre20");
    axi_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, 2'b00, 0, "strb20");
    exp_q.push_back(32'h11BB_33DD);
    axi_read(32'h8000_0020, 0, "rd20");

    // W three cycles ahead of AW, then AW ahead of W.
    axi_write(32'h8000_0030, 32'h0BAD_F00D, 4'hF, 3, 0, 0, 2'b00, 0, "w_first");
    exp_q.push_back(32'h0BAD_F00D);
    axi_read(32'h8000_0030, 0, "rd30");
    axi_write(32'h8000_0034, 32'h7654_3210, 4'hF, 0, 2, 0, 2'b00, 0, "aw_first");
    exp_q.push_back(32'h7654_3210);
    axi_read(32'h8000_0034, 0, "rd34");

    // Backpressure on R and B.
    exp_q.push_back(32'hDEAD_BEEF);
    axi_read(32'h8000_0010, 5, "rd_bp");
    axi_write(32'h8000_0040, 32'h0102_0304, 4'hF, 0, 0, 5, 2'b00, 0, "wr_bp");

    // Out of range: below base reads zero, one past the top errors.
    exp_q.push_back(32'h0000_0000);
    axi_read(32'h0000_0000, 0, "rd_oor");
    axi_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, 0, "wr0");
    axi_write(32'h8000_4000, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b10, 0, "wr_oor");
    exp_q.push_back(32'hCAFE_F00D);
    axi_read(32'h8000_0000, 0, "rd0_intact");

    // Last in-range word and unaligned low address bits.
    axi_write(32'h8000_3FFC, 32'h5A5A_A5A5, 4'hF, 0, 0, 0, 2'b00, 0, "wr_top");
    exp_q.push_back(32'h5A5A_A5A5);
    axi_read(32'h8000_3FFC, 0, "rd_top");
    exp_q.push_back(32'hDEAD_BEEF);
    axi_read(32'h8000_0013, 0, "rd_unaligned");

    // Reset while the write waits on its latency: old data survives.
    axi_write(32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b00, 1, "wr_abort");
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_rst");
    release_reset("mid_rst");
    exp_q.push_back(32'hDEAD_BEEF);
    axi_read(32'h8000_0010, 0, "rd_after_rst");
    axi_write(32'h8000_0010, 32'h1357_9BDF, 4'hF, 1, 0, 0, 2'b00, 0, "wr_after_rst");
    exp_q.push_back(32'h1357_9BDF);
    axi_read(32'h8000_0010, 0, "rd_new");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
